// File: rtl/dcdl_ctrl_pkg.sv
// Shared definitions for the DCDL lock controller: FSM states, code widths
// and the reset/entry values of the fine search.
package dcdl_ctrl_pkg;

    localparam int unsigned COARSE_N = 16;                // coarse delay cells
    localparam int unsigned C_W      = $clog2(COARSE_N + 1); // coarse count 0..16
    localparam int unsigned FINE_W   = 6;                 // fine code width
    localparam int unsigned Q_W      = 10;                // fine output port width
    localparam int unsigned K_W      = $clog2(FINE_W);    // SAR bit index width

    // Fine code with only the MSB set: first SAR trial value
    localparam logic [FINE_W-1:0] FINE_MID = FINE_W'(1 << (FINE_W - 1));
    // SAR starts on the MSB of the fine code
    localparam logic [K_W-1:0]    K_INIT   = K_W'(FINE_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COARSE = 2'd1,
        FINE   = 2'd2,
        TRACK  = 2'd3
    } state_t;

endpackage

// File: rtl/dcdl_ctrl_therm_enc.sv
// Coarse count to thermometer code: bit i is set exactly when i < c.
// Ports:
//   c        - coarse count, 0..COARSE_N
//   therm_c  - thermometer code (combinational)
module therm_enc
    import dcdl_ctrl_pkg::*;
(
    input  logic [C_W-1:0]      c,
    output logic [COARSE_N-1:0] therm_c
);

    always_comb begin
        therm_c = '0;
        for (int i = 0; i < int'(COARSE_N); i++) begin
            therm_c[i] = (C_W'(i) < c);
        end
    end

endmodule

// File: rtl/dcdl_ctrl.sv
// Digitally-controlled delay line lock controller. Acquires lock with a
// linear coarse search, a 6-bit successive-approximation fine search, then
// tracks with a filtered fine code that carries/borrows into the coarse code.
// Ports:
//   clk_ref - reference clock, rising edge
//   rst     - synchronous active-high reset
//   en      - lock-acquisition enable; low returns to IDLE holding codes
//   pd_up   - phase detector: more delay needed
//   pd_dn   - phase detector: less delay needed
//   T / Tb  - coarse thermometer code and its complement (registered)
//   Q       - fine code, upper bits zero (registered)
//   lock    - high while tracking (registered)
module dcdl_ctrl
    import dcdl_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned FILT_LEN   = 4
) (
    input  logic                clk_ref,
    input  logic                rst,
    input  logic                en,
    input  logic                pd_up,
    input  logic                pd_dn,
    output logic [COARSE_N-1:0] T,
    output logic [COARSE_N-1:0] Tb,
    output logic [Q_W-1:0]      Q,
    output logic                lock
);

    localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned A_W   = $clog2(FILT_LEN + 1) + 1;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic signed [A_W-1:0] A_MAX    = A_W'(FILT_LEN);
    localparam logic signed [A_W-1:0] A_MIN    = -A_MAX;
    localparam logic [C_W-1:0]        C_MAX    = C_W'(COARSE_N);

    state_t                state, state_nx;
    logic [C_W-1:0]        c, c_nx;
    logic [FINE_W-1:0]     f, f_nx;
    logic [K_W-1:0]        k, k_nx;
    logic signed [A_W-1:0] a, a_nx, a_step;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic                  sample_c, is_up_c, is_dn_c;
    logic [COARSE_N-1:0]   therm_nx_c;

    // Thermometer code of the next coarse count so T lands with c
    therm_enc u_therm_enc (
        .c       (c_nx),
        .therm_c (therm_nx_c)
    );

    // Next-state, code update and settle/filter bookkeeping
    always_comb begin
        state_nx = state;
        c_nx     = c;
        f_nx     = f;
        k_nx     = k;
        a_nx     = a;
        a_step   = a;
        sample_c = (cnt == CNT_LAST);
        is_up_c  = pd_up & ~pd_dn;
        is_dn_c  = pd_dn & ~pd_up;
        // Free-running settle window: one sample every SETTLE_CYC cycles
        cnt_nx   = sample_c ? '0 : cnt + CNT_W'(1);

        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (en) begin
                    state_nx = COARSE;
                end
            end

            COARSE: begin
                if (sample_c) begin
                    if (is_up_c) begin
                        if (c < C_MAX) begin
                            c_nx = c + C_W'(1);
                        end else begin
                            state_nx = FINE;
                            f_nx     = FINE_MID;
                            k_nx     = K_INIT;
                        end
                    end else if (is_dn_c) begin
                        if (c != '0) begin
                            c_nx = c - C_W'(1);
                        end
                        state_nx = FINE;
                        f_nx     = FINE_MID;
                        k_nx     = K_INIT;
                    end
                end
            end

            FINE: begin
                if (sample_c) begin
                    // Trial bit k is kept unless the detector asks for less delay
                    if (is_dn_c) begin
                        f_nx[k] = 1'b0;
                    end
                    if (k != '0) begin
                        f_nx[k - K_W'(1)] = 1'b1;
                        k_nx              = k - K_W'(1);
                    end else begin
                        state_nx = TRACK;
                        a_nx     = '0;
                    end
                end
            end

            TRACK: begin
                if (sample_c) begin
                    if (is_up_c) begin
                        a_step = a + A_W'(1);
                    end else if (is_dn_c) begin
                        a_step = a - A_W'(1);
                    end
                    a_nx = a_step;
                    // Fine code carries into / borrows from the coarse code
                    if (a_step == A_MAX) begin
                        a_nx = '0;
                        if (f != '1) begin
                            f_nx = f + FINE_W'(1);
                        end else if (c < C_MAX) begin
                            c_nx = c + C_W'(1);
                            f_nx = '0;
                        end
                    end else if (a_step == A_MIN) begin
                        a_nx = '0;
                        if (f != '0) begin
                            f_nx = f - FINE_W'(1);
                        end else if (c != '0) begin
                            c_nx = c - C_W'(1);
                            f_nx = '1;
                        end
                    end
                end
            end
        endcase

        // Any code change or state entry opens a fresh settle window
        if ((c_nx != c) || (f_nx != f) || (state_nx != state)) begin
            cnt_nx = '0;
        end

        // Disable wins over every decision and keeps the codes
        if (!en) begin
            state_nx = IDLE;
            c_nx     = c;
            f_nx     = f;
            k_nx     = K_INIT;
            a_nx     = '0;
            cnt_nx   = '0;
        end
    end

    // State, codes and registered outputs
    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state <= IDLE;
            c     <= '0;
            f     <= '0;
            k     <= K_INIT;
            a     <= '0;
            cnt   <= '0;
            T     <= '0;
            Tb    <= '1;
            Q     <= '0;
            lock  <= 1'b0;
        end else begin
            state <= state_nx;
            c     <= c_nx;
            f     <= f_nx;
            k     <= k_nx;
            a     <= a_nx;
            cnt   <= cnt_nx;
            T     <= therm_nx_c;
            Tb    <= ~therm_nx_c;
            Q     <= Q_W'(f_nx);
            lock  <= (state_nx == TRACK);
        end
    end

endmodule

// File: doc/dcdl_ctrl.md
DCDL_CTRL -- requirements
Module: dcdl_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 4: clk_ref cycles waited after any code change, or after entering a state, before the next phase-detector sample.
REQ-002 Parameter FILT_LEN, default 4: net up/dn count in TRACK that triggers one fine step.
REQ-003 Port clk_ref  input  1: single clock; all logic on the rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port en  input  1: lock-acquisition enable.
REQ-006 Port pd_up  input  1: phase detector says more delay is needed.
REQ-007 Port pd_dn  input  1: phase detector says less delay is needed.
REQ-008 Port T  output  16: coarse thermometer code for the coarse delay line.
REQ-009 Port Tb  output  16: bitwise complement of T.
REQ-010 Port Q  output  10: fine code.
REQ-011 Port lock  output  1: high when the block is in TRACK.

Function
REQ-012 The block SHALL hold a coarse count c (5 bits, range 0..16) and a fine code f (6 bits, range 0..63).
REQ-013 T[i] SHALL be 1 exactly when i < c, and Tb SHALL equal ~T on every cycle.
REQ-014 Q[5:0] SHALL equal f, and Q[9:6] SHALL be 0.
REQ-015 All outputs SHALL be registered, with one cycle of latency from a decision to the code change.
REQ-016 The settle counter SHALL restart at 0 on every code change or state entry; a sample SHALL occur on the cycle the counter equals SETTLE_CYC-1.
REQ-017 Each sample SHALL be classified as: up (pd_up=1, pd_dn=0), dn (pd_up=0, pd_dn=1), or none (both 0 or both 1).
REQ-018 The FSM SHALL have the states IDLE, COARSE, FINE and TRACK.
REQ-019 IDLE: when en=1, the FSM SHALL go to COARSE; codes are unchanged.
REQ-020 COARSE, up sample with c<16: c SHALL increment.
REQ-021 COARSE, up sample with c=16: the FSM SHALL go to FINE with f=32.
REQ-022 COARSE, dn sample: c SHALL decrement (saturating at 0), f SHALL be set to 32, and the FSM SHALL go to FINE.
REQ-023 COARSE, none sample: no change.
REQ-024 FINE SHALL run a successive-approximation search on bit index k, starting at 5.
REQ-025 FINE, dn sample: bit k SHALL be cleared; up or none: bit k SHALL be kept.
REQ-026 FINE, k>0: after each decision, bit k-1 SHALL be set and k SHALL decrement.
REQ-027 FINE, k=0: after the decision, the FSM SHALL go to TRACK.
REQ-028 TRACK SHALL use a signed filter accumulator a, range -FILT_LEN..+FILT_LEN, cleared on TRACK entry: up adds 1, dn subtracts 1, none leaves a unchanged.
REQ-029 TRACK, a reaches +FILT_LEN: f SHALL increment and a SHALL clear.
REQ-030 TRACK, increment with f=63 and c<16: c SHALL increment and f SHALL become 0; with f=63 and c=16, the codes SHALL be held.
REQ-031 TRACK, a reaches -FILT_LEN: f SHALL decrement and a SHALL clear.
REQ-032 TRACK, decrement with f=0 and c>0: c SHALL decrement and f SHALL become 63; with f=0 and c=0, the codes SHALL be held.
REQ-033 lock SHALL be 1 in TRACK only.
REQ-034 en=0 in any state SHALL move the FSM to IDLE on the next cycle, hold c and f, clear lock, and clear the settle counter and accumulator.

Reset
REQ-035 rst=1 SHALL force, on the next edge: state IDLE, c=0, f=0, k=5, a=0, settle counter 0.
REQ-036 Reset values SHALL be T=16'h0000, Tb=16'hFFFF, Q=10'h000, lock=0.
REQ-037 rst SHALL take priority over en, including mid-search and during TRACK.

Structure
REQ-038 A shared package SHALL hold the state enum, COARSE_N=16, FINE_W=6 and Q_W=10.
REQ-039 A combinational sub-module therm_enc SHALL map c (5 bits) to the 16-bit thermometer code.
REQ-040 The FSM, counters and filter SHALL reside in dcdl_ctrl.

Verification
REQ-041 Reset then en=1, pd_up held for 5 samples then pd_dn -> c steps 1..5, then c=4, f=32, state FINE.
REQ-042 In FINE from f=32, samples dn,up,up,dn,up,dn -> f=6'b011010 (26), lock=1 one cycle after the last sample.
REQ-043 In TRACK at c=3, f=63, 4 up samples -> c=4, f=0, T=16'h000F, Tb=16'hFFF0.
REQ-044 In TRACK, samples up,dn,up,up,up,up -> exactly one f increment, on the 6th sample; pd_up=pd_dn=1 samples -> no change.
REQ-045 pd_up held continuously -> c saturates at 16 (T=16'hFFFF), FINE entered with f=32.
REQ-046 rst pulse mid-FINE -> all outputs at reset values on the next edge; en drop in TRACK -> lock=0 and codes held.
